// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Built-in self-test for a small combinational gate. On start, every
//   input vector is driven onto gate_in in ascending order. Each vector is
//   held for SETTLE cycles and then for one sample cycle. On the sample
//   cycle, gate_y is compared against the expected truth table EXP_TT.
//   Mismatches are counted, and the first failing vector is recorded.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a run (honoured only when idle or done)
//   gate_in        out  [N_IN-1:0] registered stimulus to the gate under test
//   gate_y         in   gate under test output
//   busy           out  run in progress
//   done           out  run complete (sticky until next start or reset)
//   pass           out  done and no mismatches
//   err_count      out  [N_IN:0] mismatch count, saturating at 2**N_IN
//   fail_valid     out  at least one mismatch recorded in this run
//   first_fail_vec out  [N_IN-1:0] vector index of the first mismatch
module gate_response_checker #(
    parameter int                   N_IN   = 2,
    parameter logic [2**N_IN-1:0]   EXP_TT = 4'b1110,
    parameter int                   SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   gate_in,
    input  logic              gate_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]     ERR_MAX  = (N_IN + 1)'(2 ** N_IN);
    localparam logic [N_IN-1:0]   VEC_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             mismatch;
    logic [N_IN:0]    err_next;

    // Compare result and saturating count for the current sample cycle.
    // pass is registered on the final sample edge, so it must see the
    // count that includes this last comparison.
    always_comb begin
        mismatch = (gate_y != EXP_TT[gate_in]);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + (N_IN + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            gate_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= DRIVE;
                        settle_cnt     <= '0;
                        gate_in        <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                    end
                end
                DRIVE: begin
                    // The counter runs 0..SETTLE-1, so DRIVE lasts exactly SETTLE cycles.
                    if (settle_cnt == CNT_LAST) begin
                        state      <= SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_vec <= gate_in;
                        end
                    end
                    // gate_in is held at the last vector rather than wrapping.
                    if (gate_in == VEC_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state   <= DRIVE;
                        gate_in <= gate_in + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

    typedef struct {
        int err;
        int fv;
        int ffv;
        int pass;
        int lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    int         sel;
    int         mode;

    // Default instance: 2-input OR, SETTLE = 1
    logic       start2;
    logic [1:0] d2_gin;
    logic       gy2;
    logic       d2_busy, d2_done, d2_pass, d2_fv;
    logic [2:0] d2_err;
    logic [1:0] d2_ffv;

    // Second instance: 3-input OR, SETTLE = 3
    logic       start3;
    logic [2:0] d3_gin;
    logic       gy3;
    logic       d3_busy, d3_done, d3_pass, d3_fv;
    logic [3:0] d3_err;
    logic [2:0] d3_ffv;

    logic [31:0] o_gin, o_err, o_ffv;
    logic        o_busy, o_done, o_pass, o_fv;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    gate_response_checker u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .gate_in(d2_gin), .gate_y(gy2),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err),
        .fail_valid(d2_fv), .first_fail_vec(d2_ffv)
    );

    gate_response_checker #(.N_IN(3), .EXP_TT(8'hFE), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .gate_in(d3_gin), .gate_y(gy3),
        .busy(d3_busy), .done(d3_done), .pass(d3_pass), .err_count(d3_err),
        .fail_valid(d3_fv), .first_fail_vec(d3_ffv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 = OR, 1 = stuck at 0, 2 = AND, 3 = stuck at 1
    function automatic logic gval(input int m, input int v, input int n);
        case (m)
            0:       return (v != 0);
            1:       return 1'b0;
            2:       return (v == (1 << n) - 1);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        gy2    = gval(mode, int'(d2_gin), 2);
        gy3    = gval(mode, int'(d3_gin), 3);
        start2 = start && (sel == 0);
        start3 = start && (sel == 1);
        o_gin  = (sel == 1) ? 32'(d3_gin)  : 32'(d2_gin);
        o_err  = (sel == 1) ? 32'(d3_err)  : 32'(d2_err);
        o_ffv  = (sel == 1) ? 32'(d3_ffv)  : 32'(d2_ffv);
        o_busy = (sel == 1) ? d3_busy : d2_busy;
        o_done = (sel == 1) ? d3_done : d2_done;
        o_pass = (sel == 1) ? d3_pass : d2_pass;
        o_fv   = (sel == 1) ? d3_fv   : d2_fv;
    end

    function automatic exp_t model(input int s, input int m);
        exp_t       e;
        logic [7:0] tt;
        int         n, settle;
        n      = (s == 1) ? 3 : 2;
        settle = (s == 1) ? 3 : 1;
        tt     = (s == 1) ? 8'hFE : 8'h0E;
        e.err  = 0;
        e.ffv  = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gval(m, v, n) != tt[v]) begin
                if (e.err == 0) e.ffv = v;
                e.err++;
            end
        end
        e.fv   = (e.err > 0) ? 1 : 0;
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat  = 1 + (1 << n) * (settle + 1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gin"},  o_gin, 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_pass"}, 32'(o_pass), 0);
        check({tag, "_err"},  o_err, 0);
        check({tag, "_fv"},   32'(o_fv), 0);
        check({tag, "_ffv"},  o_ffv, 0);
    endtask

    task automatic run(input int s, input int m, input bit repulse, input bit chk_seq);
        exp_t e;
        int   c;
        int   settle;
        settle = (s == 1) ? 3 : 1;
        sel  = s;
        mode = m;
        sb.push_back(model(s, m));
        start = 1'b1;
        tick();
        start = 1'b0;
        // cycle 1 after the start edge: run begun, previous results cleared
        check("start_busy", 32'(o_busy), 1);
        check("start_done", 32'(o_done), 0);
        check("start_pass", 32'(o_pass), 0);
        check("start_err",  o_err, 0);
        check("start_fv",   32'(o_fv), 0);
        check("start_gin",  o_gin, 0);
        c = 1;
        while (!o_done && c < 200) begin
            if (chk_seq) check("gin_seq", o_gin, 32'((c - 1) / (settle + 1)));
            start = repulse && (c == 3 || c == 5);
            tick();
            start = 1'b0;
            c++;
        end
        e = sb.pop_front();
        check("done_latency", 32'(c), 32'(e.lat));
        check("done_busy", 32'(o_busy), 0);
        check("done_err",  o_err, 32'(e.err));
        check("done_fv",   32'(o_fv), 32'(e.fv));
        check("done_pass", 32'(o_pass), 32'(e.pass));
        if (e.fv != 0) check("done_ffv", o_ffv, 32'(e.ffv));
        tick();
        check("done_sticky", 32'(o_done), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 0;
        mode  = 0;
        tick();
        tick();
        check_zero("rst2");
        sel = 1;
        #0;
        check_zero("rst3");
        rst_n = 1'b1;
        tick();

        run(0, 0, 1'b0, 1'b1);   // good OR gate, check gate_in walk
        run(0, 1, 1'b0, 1'b0);   // stuck at 0
        run(0, 2, 1'b0, 1'b0);   // AND wired instead of OR
        run(0, 0, 1'b1, 1'b0);   // restart from DONE plus start pulses mid-run

        // reset mid-run while gate_in = 10
        sel   = 0;
        mode  = 0;
        sb.push_back(model(0, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_gin", o_gin, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_zero("idle_after_rst");
        run(0, 0, 1'b0, 1'b0);

        run(1, 0, 1'b0, 1'b1);   // 3-input OR, SETTLE = 3
        run(1, 3, 1'b0, 1'b0);   // 3-input, stuck at 1
        run(0, 3, 1'b0, 1'b0);   // 2-input, stuck at 1

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Self-checking response analyser for small combinational gates, the hardware counterpart of a truth-table bench.
- On `start`, walks every input vector of an N_IN-input gate in ascending binary order and drives it onto `gate_in`.
- Waits a programmable settle time, then samples the gate output `gate_y` and compares it against a parameterised expected truth table.
- Counts mismatches, records the first failing vector, and reports done/pass.
- Sits beside any gate under test (OR, AND, XOR, ...) as built-in self-test.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..6.
- EXP_TT, 4'b1110, expected truth table, width 2**N_IN. Bit k is the expected `gate_y` for input vector k. The default is 2-input OR.
- SETTLE, 1, cycles each vector is held before the sample cycle; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- gate_in  output  N_IN  stimulus vector to the gate under test; registered.
- gate_y  input  1  gate under test output.
- busy  output  1  high while a run is in progress.
- done  output  1  high once a run completes; sticky until the next start or reset.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  N_IN+1  mismatch count; saturates at 2**N_IN.
- fail_valid  output  1  high once any mismatch has been recorded in the current run.
- first_fail_vec  output  N_IN  vector index of the first mismatch; valid only while fail_valid is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - gate_in = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_valid = 0, first_fail_vec = 0.
  - The settle counter and vector counter clear.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start = 1 at edge t:
  - At t+1: state = DRIVE, busy = 1, gate_in = 0.
  - err_count, fail_valid and first_fail_vec are cleared.
- DRIVE:
  - gate_in is held and the settle counter increments each cycle.
  - After exactly SETTLE cycles in DRIVE, the state moves to SAMPLE.
- SAMPLE (lasts one cycle):
  - gate_in is still held.
  - On the edge leaving SAMPLE, gate_y is compared with EXP_TT[gate_in].
  - On mismatch: err_count increments (saturating). If fail_valid was 0, first_fail_vec takes gate_in and fail_valid is set.
- Vector advance:
  - If gate_in is not all ones, the next state is DRIVE with gate_in + 1 and the settle counter reset.
  - If gate_in is all ones, the next state is DONE.
  - gate_in does not wrap within a run.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0).
  - gate_in holds its last vector.
  - start = 1 restarts exactly as from IDLE; done and pass drop on the restart cycle.
- Latency: done first reads 1 at cycle 1 + 2**N_IN*(SETTLE+1) after the start edge. With the defaults this is cycle 9.
- start while busy is ignored: no restart and no counter effect.
- Reset mid-run: the asynchronous reset applies immediately, partial results are discarded, and the next start begins again at vector 0.
- gate_y is sampled only on SAMPLE-exit edges; its value in any other cycle is don't-care.
- err_count arithmetic: unsigned, N_IN+1 bits, so the value 2**N_IN is representable and is the saturation point.

Test Plan:
- Defaults, gate_y = a|b model, start pulse at cycle 0 -> gate_in sequence 00,00,01,01,10,10,11,11; done = 1 and pass = 1 at cycle 9; err_count = 0; fail_valid = 0.
- Defaults, gate_y stuck at 0 -> done at cycle 9; err_count = 3; first_fail_vec = 01; fail_valid = 1; pass = 0.
- Defaults, an AND gate connected instead of OR -> err_count = 2 (vectors 01 and 10); first_fail_vec = 01; pass = 0.
- start re-pulsed at cycles 3 and 5 during a run -> no effect; done still at cycle 9. start in DONE -> done drops the next cycle and counters clear, so a second good run gives pass = 1 at cycle 9 after the new start.
- rst_n pulsed low mid-cycle while gate_in = 10 -> all outputs 0 immediately, state IDLE. A following start and good run gives pass = 1 with the full 9-cycle latency.
- N_IN = 3, EXP_TT = 8'hFE, SETTLE = 3, 3-input OR model -> done at cycle 33; pass = 1. Forcing gate_y = 1 for every vector -> err_count = 1; first_fail_vec = 000.
